// File: rtl/data_bus_pkg.sv
// data_bus_pkg: shared bus widths and responder state encoding
package data_bus_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} dbr_state_t;
endpackage

// File: rtl/bus_word_ram.sv
// bus_word_ram: synchronous word RAM with registered read, array not reset
module bus_word_ram import data_bus_pkg::*; #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              rdata
);
    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk)
        if (en) begin
            if (we) mem[idx] <= wdata;
            else rdata <= mem[idx];
        end
endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: Req/Ready bus target with wait states and address checking
module data_bus_responder import data_bus_pkg::*; #(
    parameter int                DEPTH_WORDS = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Req,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] WD,
    input  logic              WE,
    output logic [DATA_W-1:0] RD,
    output logic              Ready,
    output logic              Err
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH_WORDS * 4);
    dbr_state_t state, nextState;
    logic [3:0] waitCnt;
    logic [ADDR_W-1:0] off;
    logic [IW-1:0] idxIn, idxQ, ramIdx;
    logic [DATA_W-1:0] wdQ, ramWd, ramRdata;
    logic bad, weQ, errQ, ramWe, access;
    assign off = A - BASE_ADDR;
    assign bad = (A[1:0] != 2'b00) || (off >= SPAN);
    assign idxIn = off[IW+1:2];
    // With zero wait states the access happens on the accept edge, so the RAM sees the live inputs
    assign ramIdx = (state == IDLE) ? idxIn : idxQ;
    assign ramWd = (state == IDLE) ? WD : wdQ;
    assign ramWe = (state == IDLE) ? WE : weQ;
    always_comb begin
        nextState = state;
        access = 1'b0;
        case (state)
            IDLE:
                if (Req) begin
                    nextState = (bad || WAIT_STATES == 0) ? RESP : WAIT;
                    access = !bad && WAIT_STATES == 0;
                end
            WAIT:
                if (waitCnt == 4'd0) begin
                    nextState = RESP;
                    access = 1'b1;
                end
            default: nextState = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            waitCnt <= '0;
            idxQ <= '0;
            wdQ <= '0;
            weQ <= 1'b0;
            errQ <= 1'b0;
        end else begin
            state <= nextState;
            if (state == IDLE && Req) begin
                idxQ <= idxIn;
                wdQ <= WD;
                weQ <= WE;
                errQ <= bad;
                waitCnt <= 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
            end else if (state == WAIT) waitCnt <= waitCnt - 4'd1;
        end
    bus_word_ram #(.DEPTH_WORDS(DEPTH_WORDS)) ram (
        .clk(clk),
        .en(access && !reset),
        .we(ramWe),
        .idx(ramIdx),
        .wdata(ramWd),
        .rdata(ramRdata)
    );
    assign Ready = (state == RESP);
    assign Err = (state == RESP) && errQ;
    assign RD = (state == RESP && !errQ && !weQ) ? ramRdata : '0;
endmodule
